// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory signal bundle between a boot source and the loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_reset_n;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_reset_n, busy, done, error
  );

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_reset_n, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// and releases the core from reset only after a clean load.
module imem_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          reset_n,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR
  } state_t;

  localparam int              TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     CAPACITY = 17'(2 ** ADDR_WIDTH);

  state_t                state;
  logic [15:0]           length;
  logic [16:0]           word_cnt;
  logic [16:0]           next_cnt;
  logic [16:0]           len_next;
  logic [1:0]            byte_idx;
  logic [23:0]           word_buf;
  logic [7:0]            csum;
  logic [TW-1:0]         tmo_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;

  assign accept   = bus.rx_valid & bus.rx_ready;
  assign next_cnt = word_cnt + 17'd1;
  assign len_next = {1'b0, bus.rx_data, length[7:0]};

  // All status outputs are pure decodes of the state register.
  assign bus.rx_ready     = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign bus.busy         = bus.rx_ready || (state == WRITE);
  assign bus.imem_we      = (state == WRITE);
  assign bus.done         = (state == DONE);
  assign bus.error        = (state == ERROR);
  assign bus.core_reset_n = (state == DONE);
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      length   <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      csum     <= '0;
      tmo_cnt  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.start) begin
            state    <= LEN0;
            word_cnt <= '0;
            byte_idx <= '0;
            csum     <= '0;
            tmo_cnt  <= '0;
          end
        end
        WRITE: begin
          word_cnt <= next_cnt;
          state    <= (next_cnt == {1'b0, length}) ? CSUM : DATA;
        end
        default: begin
          if (accept) begin
            tmo_cnt <= '0;
            csum    <= csum ^ bus.rx_data;
            case (state)
              LEN0: begin
                length[7:0] <= bus.rx_data;
                state       <= LEN1;
              end
              LEN1: begin
                length[15:8] <= bus.rx_data;
                state        <= (len_next == 17'd0 || len_next > CAPACITY) ? ERROR : DATA;
              end
              DATA: begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                  2'd0: word_buf[7:0]   <= bus.rx_data;
                  2'd1: word_buf[15:8]  <= bus.rx_data;
                  2'd2: word_buf[23:16] <= bus.rx_data;
                  default: begin
                    // Address and data are latched only when a whole word exists.
                    addr_q  <= word_cnt[ADDR_WIDTH-1:0];
                    wdata_q <= DATA_WIDTH'({bus.rx_data, word_buf});
                    state   <= WRITE;
                  end
                endcase
              end
              CSUM: state <= (bus.rx_data == csum) ? DONE : ERROR;
              default: ;
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            state <= ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
